reorder_buffer: RTL and testbench

//  Parametrised reorder buffer for the OoO core: allocates up to ALLOC_W entries/cycle in program

---
 rtl/reorder_buffer_pkg.sv | 21 ++
 rtl/reorder_buffer_ready_scan.sv | 22 ++
 rtl/reorder_buffer.sv | 181 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants and forwarding-bus record used by the ROB and core top level.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH    = 64;
  localparam int ROB_IDX_W    = 6;
  localparam int ROB_ALLOC_W  = 4;
  localparam int ROB_WB_W     = 4;
  localparam int ROB_COMMIT_W = 2;
  localparam int ROB_RD_W     = 8;
  localparam int ROB_DATA_W   = 16;
  localparam int ROB_PC_W     = 16;
  localparam int REG_IDX_W    = 3;

  // One forwarding-bus lane as seen by the core top level: {valid, idx, data}.
  typedef struct packed {
    logic                  valid;
    logic [ROB_IDX_W-1:0]  idx;
    logic [ROB_DATA_W-1:0] data;
  } fwdBus_t;

endpackage

// File: rtl/reorder_buffer_ready_scan.sv
// Contiguous-ready prefix over the oldest COMMIT_W entries: lane k retires only if lanes 0..k all can.
module reorder_buffer_ready_scan
  import reorder_buffer_pkg::*;
#(
  parameter int COMMIT_W = ROB_COMMIT_W
) (
  input  logic [COMMIT_W-1:0] entryDone,
  output logic [COMMIT_W-1:0] retireMask
);

  logic runOk;

  always_comb begin
    retireMask = '0;
    runOk      = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      runOk         = runOk & entryDone[k];
      retireMask[k] = runOk;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocate from decode, out-of-order result capture, in-order retire.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int IDX_W    = ROB_IDX_W,
  parameter int ALLOC_W  = ROB_ALLOC_W,
  parameter int WB_W     = ROB_WB_W,
  parameter int COMMIT_W = ROB_COMMIT_W,
  parameter int RD_W     = ROB_RD_W,
  parameter int DATA_W   = ROB_DATA_W,
  parameter int PC_W     = ROB_PC_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [ALLOC_W-1:0]            alloc_valid,
  input  logic [ALLOC_W*PC_W-1:0]       alloc_pc,
  input  logic [ALLOC_W-1:0]            alloc_wr,
  input  logic [ALLOC_W*REG_IDX_W-1:0]  alloc_dst,
  output logic                          alloc_ready,
  output logic [ALLOC_W*IDX_W-1:0]      alloc_idx,
  input  logic [WB_W-1:0]               fwd_valid,
  input  logic [WB_W*IDX_W-1:0]         fwd_idx,
  input  logic [WB_W*DATA_W-1:0]        fwd_data,
  input  logic [RD_W*IDX_W-1:0]         rd_idx,
  output logic [RD_W-1:0]               rd_ready,
  output logic [RD_W*DATA_W-1:0]        rd_data,
  output logic [COMMIT_W-1:0]           cm_valid,
  output logic [COMMIT_W-1:0]           cm_wr,
  output logic [COMMIT_W*REG_IDX_W-1:0] cm_dst,
  output logic [COMMIT_W*DATA_W-1:0]    cm_data,
  output logic [COMMIT_W*PC_W-1:0]      cm_pc,
  output logic [IDX_W:0]                count
);

  logic                 entValid [DEPTH];
  logic                 entReady [DEPTH];
  logic                 entWr    [DEPTH];
  logic [REG_IDX_W-1:0] entDst   [DEPTH];
  logic [PC_W-1:0]      entPc    [DEPTH];
  logic [DATA_W-1:0]    entData  [DEPTH];

  logic [IDX_W-1:0]    head, tail, laneOffset, cmIdx, lookIdx;
  logic [IDX_W-1:0]    laneIdx [ALLOC_W];
  logic [IDX_W:0]      allocNum, allocCount, retireCount;
  logic                doAlloc, lookHit;
  logic [DATA_W-1:0]   lookData;
  logic [COMMIT_W-1:0] entryDone, retireMask;

  assign alloc_ready = (((IDX_W+1)'(DEPTH) - count) >= (IDX_W+1)'(ALLOC_W));
  assign doAlloc     = alloc_ready && !flush;

  // Requesting lanes are packed: each lane's slot is tail plus the number of requesters below it.
  always_comb begin
    alloc_idx  = '0;
    laneOffset = '0;
    allocNum   = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      laneIdx[k]                    = tail + laneOffset;
      alloc_idx[k*IDX_W +: IDX_W]   = tail + laneOffset;
      if (alloc_valid[k]) begin
        laneOffset = laneOffset + IDX_W'(1);
        allocNum   = allocNum + (IDX_W+1)'(1);
      end
    end
    allocCount = doAlloc ? allocNum : '0;
  end

  always_comb begin
    entryDone = '0;
    cm_wr     = '0;
    cm_dst    = '0;
    cm_data   = '0;
    cm_pc     = '0;
    cmIdx     = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      cmIdx                               = head + IDX_W'(k);
      entryDone[k]                        = entValid[cmIdx] & entReady[cmIdx];
      cm_wr[k]                            = entWr[cmIdx];
      cm_dst[k*REG_IDX_W +: REG_IDX_W]    = entDst[cmIdx];
      cm_data[k*DATA_W +: DATA_W]         = entData[cmIdx];
      cm_pc[k*PC_W +: PC_W]               = entPc[cmIdx];
    end
  end

  reorder_buffer_ready_scan #(.COMMIT_W(COMMIT_W)) readyScan (
    .entryDone  (entryDone),
    .retireMask (retireMask)
  );

  always_comb begin
    cm_valid    = flush ? '0 : retireMask;
    retireCount = '0;
    for (int k = 0; k < COMMIT_W; k++)
      if (cm_valid[k]) retireCount = retireCount + (IDX_W+1)'(1);
  end

  // Operand lookup; a same-cycle forwarding hit bypasses storage, higher lanes override lower.
  always_comb begin
    rd_ready = '0;
    rd_data  = '0;
    lookIdx  = '0;
    lookHit  = 1'b0;
    lookData = '0;
    for (int r = 0; r < RD_W; r++) begin
      lookIdx  = rd_idx[r*IDX_W +: IDX_W];
      lookHit  = entValid[lookIdx] & entReady[lookIdx];
      lookData = entData[lookIdx];
      for (int w = 0; w < WB_W; w++) begin
        if (fwd_valid[w] && fwd_idx[w*IDX_W +: IDX_W] == lookIdx && entValid[lookIdx]) begin
          lookHit  = 1'b1;
          lookData = fwd_data[w*DATA_W +: DATA_W];
        end
      end
      rd_ready[r]                 = lookHit;
      rd_data[r*DATA_W +: DATA_W] = lookData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entValid[i] <= 1'b0;
        entReady[i] <= 1'b0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entValid[i] <= 1'b0;
        entReady[i] <= 1'b0;
      end
    end else begin
      for (int w = 0; w < WB_W; w++)
        if (fwd_valid[w] && entValid[fwd_idx[w*IDX_W +: IDX_W]])
          entReady[fwd_idx[w*IDX_W +: IDX_W]] <= 1'b1;
      for (int k = 0; k < COMMIT_W; k++) begin
        if (cm_valid[k]) begin
          entValid[head + IDX_W'(k)] <= 1'b0;
          entReady[head + IDX_W'(k)] <= 1'b0;
        end
      end
      // Allocation only targets free slots, so it never collides with a retiring entry.
      if (doAlloc) begin
        for (int k = 0; k < ALLOC_W; k++) begin
          if (alloc_valid[k]) begin
            entValid[laneIdx[k]] <= 1'b1;
            entReady[laneIdx[k]] <= 1'b0;
          end
        end
      end
      head  <= head + retireCount[IDX_W-1:0];
      tail  <= tail + allocCount[IDX_W-1:0];
      count <= count + allocCount - retireCount;
    end
  end

  // Payload fields carry no reset; they are only observed while the entry is valid.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int w = 0; w < WB_W; w++)
        if (fwd_valid[w] && entValid[fwd_idx[w*IDX_W +: IDX_W]])
          entData[fwd_idx[w*IDX_W +: IDX_W]] <= fwd_data[w*DATA_W +: DATA_W];
      if (doAlloc) begin
        for (int k = 0; k < ALLOC_W; k++) begin
          if (alloc_valid[k]) begin
            entWr[laneIdx[k]]  <= alloc_wr[k];
            entDst[laneIdx[k]] <= alloc_dst[k*REG_IDX_W +: REG_IDX_W];
            entPc[laneIdx[k]]  <= alloc_pc[k*PC_W +: PC_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table for the basic alloc/writeback/commit flow,
// then hand-written sequences for fill, wrap, bypass, flush and asynchronous reset.
module tb_reorder_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [3:0]   allocValid;
  logic [63:0]  allocPc;
  logic [3:0]   allocWr;
  logic [11:0]  allocDst;
  logic         allocReady;
  logic [23:0]  allocIdx;
  logic [3:0]   fwdValid;
  logic [23:0]  fwdIdx;
  logic [63:0]  fwdData;
  logic [47:0]  rdIdx;
  logic [7:0]   rdReady;
  logic [127:0] rdData;
  logic [1:0]   cmValid;
  logic [1:0]   cmWr;
  logic [5:0]   cmDst;
  logic [31:0]  cmData;
  logic [31:0]  cmPc;
  logic [6:0]   count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .alloc_valid (allocValid),
    .alloc_pc    (allocPc),
    .alloc_wr    (allocWr),
    .alloc_dst   (allocDst),
    .alloc_ready (allocReady),
    .alloc_idx   (allocIdx),
    .fwd_valid   (fwdValid),
    .fwd_idx     (fwdIdx),
    .fwd_data    (fwdData),
    .rd_idx      (rdIdx),
    .rd_ready    (rdReady),
    .rd_data     (rdData),
    .cm_valid    (cmValid),
    .cm_wr       (cmWr),
    .cm_dst      (cmDst),
    .cm_data     (cmData),
    .cm_pc       (cmPc),
    .count       (count)
  );

  typedef struct packed {
    logic [3:0]  allocValid;
    logic [63:0] allocPc;
    logic [3:0]  fwdValid;
    logic [23:0] fwdIdx;
    logic [63:0] fwdData;
    logic [5:0]  rdIdx;
    logic        expAllocReady;
    logic [23:0] expAllocIdx;
    logic [6:0]  expCount;
    logic [1:0]  expCmValid;
    logic [15:0] expCmPc0;
    logic [15:0] expCmData0;
    logic [3:0]  expCmWrDst0;
    logic        expRdReady;
    logic [15:0] expRdData;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    flush      = 1'b0;
    allocValid = '0;
    allocPc    = '0;
    allocWr    = 4'b0101;
    allocDst   = {3'd4, 3'd3, 3'd2, 3'd1};
    fwdValid   = '0;
    fwdIdx     = '0;
    fwdData    = '0;
    rdIdx      = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    allocValid = v.allocValid;
    allocPc    = v.allocPc;
    fwdValid   = v.fwdValid;
    fwdIdx     = v.fwdIdx;
    fwdData    = v.fwdData;
    rdIdx      = {8{v.rdIdx}};
  endtask

  task automatic setFwd(input int lane, input int idx, input logic [15:0] data);
    fwdValid[lane]          = 1'b1;
    fwdIdx[lane*6 +: 6]     = 6'(idx);
    fwdData[lane*16 +: 16]  = data;
  endtask

  initial begin
    int  expPc;
    bit  done;
    vec_t v;

    // Fields: allocValid, allocPc, fwdValid, fwdIdx, fwdData, rdIdx,
    //         expAllocReady, expAllocIdx, expCount, expCmValid, expCmPc0, expCmData0, expCmWrDst0, expRdReady, expRdData
    vecs[0] = '{4'hF, {16'd6, 16'd4, 16'd2, 16'd0}, 4'h0, 24'h0, 64'h0, 6'd5,
                1'b1, {6'd3, 6'd2, 6'd1, 6'd0}, 7'd0, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0, 16'h0};
    vecs[1] = '{4'h0, 64'h0, 4'b0001, {18'h0, 6'd2}, {48'h0, 16'h1234}, 6'd2,
                1'b1, {4{6'd4}}, 7'd4, 2'b00, 16'h0, 16'h0, 4'h0, 1'b1, 16'h1234};
    vecs[2] = '{4'h0, 64'h0, 4'b0011, {12'h0, 6'd1, 6'd0}, {32'h0, 16'hBBBB, 16'hAAAA}, 6'd2,
                1'b1, {4{6'd4}}, 7'd4, 2'b00, 16'h0, 16'h0, 4'h0, 1'b1, 16'h1234};
    vecs[3] = '{4'h0, 64'h0, 4'h0, 24'h0, 64'h0, 6'd1,
                1'b1, {4{6'd4}}, 7'd4, 2'b11, 16'd0, 16'hAAAA, 4'b1001, 1'b1, 16'hBBBB};
    vecs[4] = '{4'h0, 64'h0, 4'h0, 24'h0, 64'h0, 6'd3,
                1'b1, {4{6'd4}}, 7'd2, 2'b01, 16'd4, 16'h1234, 4'b1011, 1'b0, 16'h0};
    vecs[5] = '{4'h0, 64'h0, 4'b1100, {6'd3, 6'd3, 12'h0}, {16'h4444, 16'h3333, 32'h0}, 6'd3,
                1'b1, {4{6'd4}}, 7'd1, 2'b00, 16'h0, 16'h0, 4'h0, 1'b1, 16'h4444};
    vecs[6] = '{4'h0, 64'h0, 4'h0, 24'h0, 64'h0, 6'd3,
                1'b1, {4{6'd4}}, 7'd1, 2'b01, 16'd6, 16'h4444, 4'b0100, 1'b1, 16'h4444};
    vecs[7] = '{4'h0, 64'h0, 4'h0, 24'h0, 64'h0, 6'd3,
                1'b1, {4{6'd4}}, 7'd0, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0, 16'h0};

    rst_n = 1'b0;
    clearInputs();
    #12;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      applyStimulus(v);
      #2;
      checkOutput($sformatf("vec%0d_alloc_ready", i), 32'(allocReady), 32'(v.expAllocReady));
      checkOutput($sformatf("vec%0d_alloc_idx", i), 32'(allocIdx), 32'(v.expAllocIdx));
      checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(v.expCount));
      checkOutput($sformatf("vec%0d_cm_valid", i), 32'(cmValid), 32'(v.expCmValid));
      checkOutput($sformatf("vec%0d_rd_ready", i), 32'(rdReady[0]), 32'(v.expRdReady));
      if (v.expCmValid[0]) begin
        checkOutput($sformatf("vec%0d_cm_pc0", i), 32'(cmPc[15:0]), 32'(v.expCmPc0));
        checkOutput($sformatf("vec%0d_cm_data0", i), 32'(cmData[15:0]), 32'(v.expCmData0));
        checkOutput($sformatf("vec%0d_cm_wrdst0", i), 32'({cmWr[0], cmDst[2:0]}), 32'(v.expCmWrDst0));
      end
      if (v.expRdReady)
        checkOutput($sformatf("vec%0d_rd_data", i), 32'(rdData[15:0]), 32'(v.expRdData));
      step();
    end

    // Fill to DEPTH, confirm back-pressure and dropped request, then drain four.
    clearInputs();
    flush = 1'b1;
    step();
    for (int c = 0; c < 16; c++) begin
      clearInputs();
      allocValid = 4'hF;
      step();
    end
    clearInputs();
    allocValid = 4'hF;
    #2;
    checkOutput("full_count", 32'(count), 32'd64);
    checkOutput("full_alloc_ready", 32'(allocReady), 32'd0);
    step();
    clearInputs();
    for (int k = 0; k < 4; k++) setFwd(k, k, 16'(k));
    #2;
    checkOutput("full_drop_count", 32'(count), 32'd64);
    checkOutput("full_drop_tail", 32'(allocIdx[5:0]), 32'd0);
    step();
    clearInputs();
    #2;
    checkOutput("full_cm_valid", 32'(cmValid), 32'b11);
    step();
    #2;
    checkOutput("full_commit2_count", 32'(count), 32'd62);
    checkOutput("full_commit2_ready", 32'(allocReady), 32'd0);
    step();
    #2;
    checkOutput("full_commit4_count", 32'(count), 32'd60);
    checkOutput("full_commit4_ready", 32'(allocReady), 32'd1);

    // Move tail to 62, drain everything in order, then allocate across the wrap point.
    clearInputs();
    flush = 1'b1;
    step();
    for (int c = 0; c < 16; c++) begin
      clearInputs();
      allocValid = (c < 15) ? 4'hF : 4'h3;
      for (int k = 0; k < 4; k++) allocPc[k*16 +: 16] = 16'(c*4 + k);
      step();
    end
    #2;
    checkOutput("wrap_fill_count", 32'(count), 32'd62);
    expPc = 0;
    done  = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      clearInputs();
      if (c < 16)
        for (int k = 0; k < 4; k++)
          if (c*4 + k < 62) setFwd(k, c*4 + k, 16'(c*4 + k));
      #2;
      if (cmValid[1] && !cmValid[0])
        checkOutput("wrap_drain_contiguous", 32'(cmValid), 32'b11);
      for (int k = 0; k < 2; k++) begin
        if (cmValid[k]) begin
          checkOutput("wrap_drain_pc", 32'(cmPc[k*16 +: 16]), 32'(expPc));
          expPc++;
        end
      end
      if (c >= 16 && count == 7'd0) done = 1'b1;
      step();
    end
    checkOutput("wrap_drain_done", 32'(done), 32'd1);
    checkOutput("wrap_drain_total", 32'(expPc), 32'd62);
    clearInputs();
    allocValid = 4'hF;
    allocPc    = {16'd103, 16'd102, 16'd101, 16'd100};
    #2;
    checkOutput("wrap_alloc_idx", 32'(allocIdx), 32'({6'd1, 6'd0, 6'd63, 6'd62}));
    step();
    clearInputs();
    setFwd(0, 62, 16'h0062);
    setFwd(1, 63, 16'h0063);
    setFwd(2, 0, 16'h0000);
    setFwd(3, 1, 16'h0001);
    step();
    clearInputs();
    #2;
    checkOutput("wrap_cm_valid_a", 32'(cmValid), 32'b11);
    checkOutput("wrap_cm_pc_a", cmPc, {16'd101, 16'd100});
    step();
    #2;
    checkOutput("wrap_cm_valid_b", 32'(cmValid), 32'b11);
    checkOutput("wrap_cm_pc_b", cmPc, {16'd103, 16'd102});
    step();
    #2;
    checkOutput("wrap_empty_count", 32'(count), 32'd0);

    // Same-cycle lookup bypass, then the stored value.
    clearInputs();
    flush = 1'b1;
    step();
    clearInputs();
    allocValid = 4'hF;
    step();
    step();
    clearInputs();
    rdIdx[5:0]   = 6'd5;
    rdIdx[47:42] = 6'd6;
    setFwd(1, 5, 16'hBEEF);
    #2;
    checkOutput("bypass_rd_ready", 32'(rdReady[0]), 32'd1);
    checkOutput("bypass_rd_data", 32'(rdData[15:0]), 32'hBEEF);
    checkOutput("bypass_other_not_ready", 32'(rdReady[7]), 32'd0);
    step();
    clearInputs();
    rdIdx[5:0] = 6'd5;
    setFwd(0, 0, 16'h1111);
    #2;
    checkOutput("stored_rd_ready", 32'(rdReady[0]), 32'd1);
    checkOutput("stored_rd_data", 32'(rdData[15:0]), 32'hBEEF);
    step();

    // Flush with a retire-ready head, allocation and writeback all pending.
    clearInputs();
    flush      = 1'b1;
    allocValid = 4'hF;
    setFwd(1, 1, 16'h2222);
    #2;
    checkOutput("flush_cm_valid", 32'(cmValid), 32'd0);
    checkOutput("flush_pre_count", 32'(count), 32'd8);
    step();
    clearInputs();
    #2;
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_alloc_idx0", 32'(allocIdx[5:0]), 32'd0);
    checkOutput("flush_rd_ready", 32'(rdReady[0]), 32'd0);
    checkOutput("flush_post_cm_valid", 32'(cmValid), 32'd0);

    // Asynchronous reset mid-cycle clears state without a clock edge.
    allocValid = 4'hF;
    step();
    clearInputs();
    #2;
    checkOutput("pre_reset_count", 32'(count), 32'd4);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_count", 32'(count), 32'd0);
    checkOutput("async_reset_alloc_idx", 32'(allocIdx), 32'd0);
    #2;
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
